// File: rtl/commit_trace_buffer.sv
// Multi-lane commit tracer: circular capture buffer with arm/trigger sessions,
// a post-trigger entry budget and an oldest-first valid/ready drain port.
module commit_trace_buffer #(
   parameter int LANES     = 2,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 8
) (
   input  logic                                      hz100,
   input  logic                                      reset,
   input  logic [LANES-1:0]                          lane_enable,
   input  logic [LANES-1:0]                          lane_freeze,
   input  logic [LANES*32-1:0]                       lane_instr,
   input  logic [LANES*DATA_W-1:0]                   lane_result,
   input  logic                                      arm,
   input  logic                                      trigger,
   input  logic                                      rd_ready,
   output logic                                      rd_valid,
   output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] rd_lane,
   output logic [31:0]                               rd_instr,
   output logic [DATA_W-1:0]                         rd_result,
   output logic [15:0]                               rd_stamp,
   output logic [1:0]                                state,
   output logic [$clog2(DEPTH+1)-1:0]                count,
   output logic                                      overflow
);
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int NW = $clog2(2*DEPTH+1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

   state_t          state_q;
   logic [PW-1:0]   head_q, tail_q;
   logic [CW-1:0]   count_q;
   logic [NW-1:0]   rem_q;
   logic [15:0]     stamp_q;
   logic            overflow_q;

   logic [LW-1:0]     mem_lane   [DEPTH];
   logic [31:0]       mem_instr  [DEPTH];
   logic [DATA_W-1:0] mem_result [DEPTH];
   logic [15:0]       mem_stamp  [DEPTH];

   logic [LANES-1:0]  wr_en;
   logic [PW-1:0]     wr_slot [LANES];
   logic [NW-1:0]     n_wr, total, drop;
   logic [CW-1:0]     new_count;

   // Lanes claim consecutive slots in ascending order; in POST only the
   // lowest lanes that still fit the remaining budget are kept.
   always_comb begin
      wr_en = '0;
      n_wr  = '0;
      for (int i = 0; i < LANES; i++) begin
         wr_slot[i] = tail_q + n_wr[PW-1:0];
         if (lane_enable[i] && !lane_freeze[i] &&
             ((state_q == S_PRE && !arm) || (state_q == S_POST && n_wr < rem_q))) begin
            wr_en[i] = 1'b1;
            n_wr     = n_wr + NW'(1);
         end
      end
      total = NW'(count_q) + n_wr;
      if (total > NW'(DEPTH)) begin
         new_count = CW'(DEPTH);
         drop      = total - NW'(DEPTH);
      end else begin
         new_count = total[CW-1:0];
         drop      = '0;
      end
   end

   always_ff @(posedge hz100 or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         rem_q      <= '0;
         stamp_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         stamp_q <= stamp_q + 16'd1;
         case (state_q)
            S_IDLE: begin
               if (arm) begin
                  state_q    <= S_PRE;
                  head_q     <= '0;
                  tail_q     <= '0;
                  count_q    <= '0;
                  overflow_q <= 1'b0;
               end
            end
            S_PRE: begin
               if (arm) begin
                  head_q     <= '0;
                  tail_q     <= '0;
                  count_q    <= '0;
                  overflow_q <= 1'b0;
               end else begin
                  tail_q  <= tail_q + n_wr[PW-1:0];
                  head_q  <= head_q + drop[PW-1:0];
                  count_q <= new_count;
                  if (drop != '0) overflow_q <= 1'b1;
                  if (trigger) begin
                     state_q <= S_POST;
                     rem_q   <= NW'(POST_TRIG);
                  end
               end
            end
            S_POST: begin
               tail_q  <= tail_q + n_wr[PW-1:0];
               head_q  <= head_q + drop[PW-1:0];
               count_q <= new_count;
               rem_q   <= rem_q - n_wr;
               if (n_wr == rem_q) state_q <= S_DONE;
            end
            S_DONE: begin
               if (arm) begin
                  state_q    <= S_PRE;
                  head_q     <= '0;
                  tail_q     <= '0;
                  count_q    <= '0;
                  overflow_q <= 1'b0;
               end else if (count_q == '0) begin
                  state_q <= S_IDLE;
               end else if (rd_ready) begin
                  head_q  <= head_q + PW'(1);
                  count_q <= count_q - CW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Storage has no reset; every read path is gated by rd_valid.
   always_ff @(posedge hz100) begin
      for (int i = 0; i < LANES; i++) begin
         if (wr_en[i]) begin
            mem_lane[wr_slot[i]]   <= LW'(i);
            mem_instr[wr_slot[i]]  <= lane_instr[32*i +: 32];
            mem_result[wr_slot[i]] <= lane_result[DATA_W*i +: DATA_W];
            mem_stamp[wr_slot[i]]  <= stamp_q;
         end
      end
   end

   assign rd_valid  = (state_q == S_DONE) && (count_q != '0);
   assign rd_lane   = rd_valid ? mem_lane[head_q]   : '0;
   assign rd_instr  = rd_valid ? mem_instr[head_q]  : '0;
   assign rd_result = rd_valid ? mem_result[head_q] : '0;
   assign rd_stamp  = rd_valid ? mem_stamp[head_q]  : '0;
   assign state     = state_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: a queue model of the capture buffer
// predicts every drained entry; a second instance exercises a short post budget.
module tb_commit_trace_buffer;
  localparam int LANES = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int PT    = 8;
  localparam int W     = 1 + 32 + DW + 16;

  logic              hz100, reset;
  logic [1:0]        lane_enable, lane_freeze;
  logic [63:0]       lane_instr, lane_result;
  logic              arm, trigger, rd_ready;

  logic              rd_valid, overflow;
  logic [0:0]        rd_lane;
  logic [31:0]       rd_instr;
  logic [DW-1:0]     rd_result;
  logic [15:0]       rd_stamp;
  logic [1:0]        state;
  logic [4:0]        count;

  logic              d3_rd_valid, d3_overflow;
  logic [0:0]        d3_rd_lane;
  logic [31:0]       d3_rd_instr;
  logic [DW-1:0]     d3_rd_result;
  logic [15:0]       d3_rd_stamp;
  logic [1:0]        d3_state;
  logic [4:0]        d3_count;

  commit_trace_buffer #(.LANES(LANES), .DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(PT)) u_dut (
    .hz100(hz100), .reset(reset), .lane_enable(lane_enable), .lane_freeze(lane_freeze),
    .lane_instr(lane_instr), .lane_result(lane_result), .arm(arm), .trigger(trigger),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_lane(rd_lane), .rd_instr(rd_instr),
    .rd_result(rd_result), .rd_stamp(rd_stamp), .state(state), .count(count),
    .overflow(overflow));

  commit_trace_buffer #(.LANES(LANES), .DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(3)) u_dut3 (
    .hz100(hz100), .reset(reset), .lane_enable(lane_enable), .lane_freeze(lane_freeze),
    .lane_instr(lane_instr), .lane_result(lane_result), .arm(arm), .trigger(trigger),
    .rd_ready(rd_ready), .rd_valid(d3_rd_valid), .rd_lane(d3_rd_lane), .rd_instr(d3_rd_instr),
    .rd_result(d3_rd_result), .rd_stamp(d3_rd_stamp), .state(d3_state), .count(d3_count),
    .overflow(d3_overflow));

  // clock / reset
  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  // scoreboard and model state
  logic [W-1:0] exp_q[$];
  int           m_state, m_rem;
  logic [15:0]  m_stamp;
  logic         m_ovf;
  int           checks, errors;
  string        phase;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_valid;
    exp_valid = (m_state == 3) && (exp_q.size() != 0);
    chk({phase, "_state"}, 128'(state), 128'(m_state));
    chk({phase, "_count"}, 128'(count), 128'(exp_q.size()));
    chk({phase, "_overflow"}, 128'(overflow), 128'(m_ovf));
    chk({phase, "_rd_valid"}, 128'(rd_valid), 128'(exp_valid));
    if (exp_valid)
      chk({phase, "_head"}, 128'({rd_lane, rd_instr, rd_result, rd_stamp}), 128'(exp_q[0]));
    else
      chk({phase, "_rd_zero"}, 128'({rd_lane, rd_instr, rd_result, rd_stamp}), 128'(0));
  endtask

  function automatic logic [W-1:0] mk(input int i);
    logic [0:0] ln;
    ln = 1'(i);
    return {ln, lane_instr[32*i +: 32], lane_result[DW*i +: DW], m_stamp};
  endfunction

  // model advances on the edge, then outputs are compared 1 time unit later
  task automatic tick();
    case (m_state)
      0: if (arm) begin exp_q.delete(); m_ovf = 1'b0; m_state = 1; end
      1: begin
        if (arm) begin
          exp_q.delete(); m_ovf = 1'b0;
        end else begin
          for (int i = 0; i < LANES; i++) begin
            if (lane_enable[i] && !lane_freeze[i]) begin
              exp_q.push_back(mk(i));
              if (exp_q.size() > DEPTH) begin void'(exp_q.pop_front()); m_ovf = 1'b1; end
            end
          end
          if (trigger) begin m_state = 2; m_rem = PT; end
        end
      end
      2: begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_enable[i] && !lane_freeze[i] && m_rem > 0) begin
            exp_q.push_back(mk(i));
            if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            m_rem--;
          end
        end
        if (m_rem == 0) m_state = 3;
      end
      default: begin
        if (arm) begin exp_q.delete(); m_ovf = 1'b0; m_state = 1; end
        else if (exp_q.size() == 0) m_state = 0;
        else if (rd_ready) void'(exp_q.pop_front());
      end
    endcase
    @(posedge hz100);
    #1;
    m_stamp++;
    check_all();
  endtask

  // driver tasks
  task automatic cyc(input logic [1:0] en, input logic [1:0] frz, input logic a, input logic t);
    lane_enable = en;
    lane_freeze = frz;
    arm         = a;
    trigger     = t;
    lane_instr  = {$urandom, $urandom};
    lane_result = {$urandom, $urandom};
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    lane_enable = '0; lane_freeze = '0; arm = 1'b0; trigger = 1'b0; rd_ready = 1'b0;
    #1;
    exp_q.delete(); m_state = 0; m_rem = 0; m_ovf = 1'b0; m_stamp = '0;
    check_all();
    @(posedge hz100);
    #1;
    reset = 1'b1;
    check_all();
  endtask

  task automatic drain(input string tag);
    rd_ready = 1'b1;
    for (int n = 0; n < 64 && m_state != 0; n++) cyc(2'b00, 2'b00, 1'b0, 1'b0);
    chk({tag, "_drain_idle"}, 128'(state), 128'(0));
    rd_ready = 1'b0;
  endtask

  logic [15:0] pre_stamp [12];
  logic [15:0] s1, s2;
  logic [31:0] i0a, i1a, i0b, hold_instr;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    lane_enable = '0; lane_freeze = '0; lane_instr = '0; lane_result = '0;
    arm = 1'b0; trigger = 1'b0; rd_ready = 1'b0;
    m_stamp = '0;
    @(posedge hz100); #1;

    phase = "t1";
    do_reset();
    cyc(2'b00, 2'b00, 1'b1, 1'b0);
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    cyc(2'b11, 2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cyc(2'b11, 2'b00, 1'b0, 1'b0);
    chk("t1_done_state", 128'(state), 128'(3));
    chk("t1_done_count", 128'(count), 128'(12));
    chk("t1_first_lane", 128'(rd_lane), 128'(0));
    drain("t1");

    phase = "t2";
    do_reset();
    cyc(2'b00, 2'b00, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(2'b11, 2'b10, 1'b0, 1'b0);
    cyc(2'b11, 2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cyc(2'b11, 2'b00, 1'b0, 1'b0);
    chk("t2_done_count", 128'(count), 128'(13));
    rd_ready = 1'b1;
    cyc(2'b00, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 2'b00, 1'b1, 1'b0);
    chk("t2_abort_state", 128'(state), 128'(1));
    chk("t2_abort_count", 128'(count), 128'(0));
    rd_ready = 1'b0;

    phase = "t3";
    do_reset();
    cyc(2'b00, 2'b00, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      pre_stamp[k] = m_stamp;
      cyc(2'b11, 2'b00, 1'b0, (k == 11) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 4; k++) cyc(2'b11, 2'b00, 1'b0, 1'b0);
    chk("t3_count", 128'(count), 128'(16));
    chk("t3_overflow", 128'(overflow), 128'(1));
    chk("t3_first_stamp", 128'(rd_stamp), 128'(pre_stamp[8]));

    phase = "t5";
    hold_instr = exp_q[0][DW+16 +: 32];
    for (int k = 0; k < 5; k++) begin
      cyc(2'b00, 2'b00, 1'b0, 1'b0);
      chk("t5_hold_valid", 128'(rd_valid), 128'(1));
      chk("t5_hold_instr", 128'(rd_instr), 128'(hold_instr));
    end
    drain("t5");

    phase = "t4";
    do_reset();
    cyc(2'b00, 2'b00, 1'b1, 1'b0);
    cyc(2'b00, 2'b00, 1'b0, 1'b1);
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    s1 = m_stamp - 16'd1; i0a = lane_instr[31:0]; i1a = lane_instr[63:32];
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    s2 = m_stamp - 16'd1; i0b = lane_instr[31:0];
    chk("t4_state", 128'(d3_state), 128'(3));
    chk("t4_count", 128'(d3_count), 128'(3));
    chk("t4_e0", 128'({d3_rd_valid, d3_rd_lane, d3_rd_instr, d3_rd_stamp}), 128'({1'b1, 1'b0, i0a, s1}));
    rd_ready = 1'b1;
    cyc(2'b00, 2'b00, 1'b0, 1'b0);
    chk("t4_e1", 128'({d3_rd_valid, d3_rd_lane, d3_rd_instr, d3_rd_stamp}), 128'({1'b1, 1'b1, i1a, s1}));
    cyc(2'b00, 2'b00, 1'b0, 1'b0);
    chk("t4_e2", 128'({d3_rd_valid, d3_rd_lane, d3_rd_instr, d3_rd_stamp}), 128'({1'b1, 1'b0, i0b, s2}));
    cyc(2'b00, 2'b00, 1'b0, 1'b0);
    chk("t4_empty", 128'({d3_rd_valid, d3_count}), 128'(0));
    cyc(2'b00, 2'b00, 1'b0, 1'b0);
    chk("t4_idle", 128'(d3_state), 128'(0));
    rd_ready = 1'b0;

    phase = "t6";
    do_reset();
    cyc(2'b00, 2'b00, 1'b1, 1'b0);
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    cyc(2'b11, 2'b00, 1'b0, 1'b1);
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    cyc(2'b01, 2'b00, 1'b0, 1'b0);
    chk("t6_pre_count", 128'(count), 128'(9));
    chk("t6_pre_state", 128'(state), 128'(2));
    phase = "t6_rst";
    do_reset();
    phase = "t6_after";
    cyc(2'b00, 2'b00, 1'b1, 1'b0);
    cyc(2'b11, 2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cyc(2'b11, 2'b00, 1'b0, 1'b0);
    chk("t6_stamp_restart", 128'(rd_stamp), 128'(1));
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
